// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes on operand and result sides.
// Single-cycle ADD/SUB/AND/NOT/OR/XOR/SHL plus a shift-add multiply taking WIDTH cycles.
//
// state | meaning
// IDLE  | waiting for an operation; in_ready high
// BUSY  | iterative multiply, one multiplier bit per cycle
// DONE  | result and flags presented until out_ready
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [2:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       Z
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [2:0]       z_q, z_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] sum, diff, shl_res, alu_res;
    logic [WIDTH-1:0] mul_sum, mul_next;
    logic [SHW-1:0]   shamt;
    logic             shl_oor, alu_v, mul_last;

    function automatic logic [2:0] flags(input logic [WIDTH-1:0] r, input logic v);
        return {r[WIDTH-1], v, (r == '0)};
    endfunction

    assign sum   = Ain + Bin;
    assign diff  = Ain - Bin;
    assign shamt = Bin[SHW-1:0];

    // Out-of-range shifts (high Bin bits set, or amount >= WIDTH) yield zero
    assign shl_oor = (|(Bin >> SHW)) || ({{(32-SHW){1'b0}}, shamt} >= 32'(WIDTH));
    assign shl_res = shl_oor ? '0 : (Ain << shamt);

    always_comb begin
        alu_res = sum;
        alu_v   = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (sum[WIDTH-1] != Ain[WIDTH-1]);
        case (ALUop)
            OP_SUB: begin
                alu_res = diff;
                alu_v   = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (diff[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_AND: begin alu_res = Ain & Bin; alu_v = 1'b0; end
            OP_NOT: begin alu_res = ~Bin;      alu_v = 1'b0; end
            OP_OR:  begin alu_res = Ain | Bin; alu_v = 1'b0; end
            OP_XOR: begin alu_res = Ain ^ Bin; alu_v = 1'b0; end
            OP_SHL: begin alu_res = shl_res;   alu_v = 1'b0; end
            default: ;
        endcase
    end

    assign mul_sum  = acc_q + (a_q << cnt_q);
    assign mul_next = b_q[cnt_q] ? mul_sum : acc_q;
    assign mul_last = (cnt_q == SHW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        z_d     = z_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = Ain;
                    b_d = Bin;
                    if (ALUop == OP_MUL) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end else begin
                        out_d   = alu_res;
                        z_d     = flags(alu_res, alu_v);
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                if (mul_last) begin
                    out_d   = mul_next;
                    z_d     = flags(mul_next, 1'b0);
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            z_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            z_q     <= z_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = valid_q;
    assign out       = out_q;
    assign Z         = z_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a 16-bit and an 8-bit instance share clock, reset and operand buses.
module tb_seq_alu;

    logic        clk;
    logic        reset_n;
    logic [2:0]  ALUop;
    logic [15:0] Ain, Bin;

    logic        iv16, rdy16, ov16, or16;
    logic [15:0] out16;
    logic [2:0]  z16;
    logic        iv8, rdy8, ov8, or8;
    logic [7:0]  out8;
    logic [2:0]  z8;

    int checks = 0;
    int fails  = 0;

    bit          sel;
    logic        o_ready, o_valid;
    logic [15:0] o_out;
    logic [2:0]  o_z;

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv16), .in_ready(rdy16),
        .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .out_valid(ov16),
        .out_ready(or16), .out(out16), .Z(z16)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(rdy8),
        .Ain(Ain[7:0]), .Bin(Bin[7:0]), .ALUop(ALUop), .out_valid(ov8),
        .out_ready(or8), .out(out8), .Z(z8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (sel) begin
            o_ready = rdy8;
            o_valid = ov8;
            o_out   = {8'h00, out8};
            o_z     = z8;
        end else begin
            o_ready = rdy16;
            o_valid = ov16;
            o_out   = out16;
            o_z     = z16;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        check({tag, " ready_before"}, 32'(o_ready), 32'd1);
        ALUop = op;
        Ain   = a;
        Bin   = b;
        if (sel) iv8 = 1'b1; else iv16 = 1'b1;
        @(posedge clk);
        #1;
        iv16 = 1'b0;
        iv8  = 1'b0;
    endtask

    task automatic consume(input string tag);
        if (sel) or8 = 1'b1; else or16 = 1'b1;
        @(posedge clk);
        #1;
        or16 = 1'b0;
        or8  = 1'b0;
        check({tag, " valid_after"}, 32'(o_valid), 32'd0);
        check({tag, " ready_after"}, 32'(o_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] ex_out,
                       input logic [2:0] ex_z, input int ex_lat);
        int lat;
        bit rdy_bad;
        issue(tag, op, a, b);
        lat     = 0;
        rdy_bad = 1'b0;
        while (o_valid !== 1'b1 && lat < 40) begin
            if (o_ready !== 1'b0) rdy_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(ex_lat));
        if (ex_lat > 0) check({tag, " busy_ready"}, 32'(rdy_bad), 32'd0);
        check({tag, " out"}, 32'(o_out), 32'(ex_out));
        check({tag, " Z"}, 32'(o_z), 32'(ex_z));
        check({tag, " ready_done"}, 32'(o_ready), 32'd0);
        consume(tag);
    endtask

    initial begin
        bit saw_valid;
        reset_n = 1'b0;
        ALUop = 3'b000; Ain = '0; Bin = '0;
        iv16 = 1'b0; or16 = 1'b0; iv8 = 1'b0; or8 = 1'b0;
        sel = 1'b0;
        #1;
        check("rst16 ready", 32'(o_ready), 32'd1);
        check("rst16 valid", 32'(o_valid), 32'd0);
        check("rst16 out", 32'(o_out), 32'd0);
        check("rst16 Z", 32'(o_z), 32'd0);
        sel = 1'b1;
        #1;
        check("rst8 ready", 32'(o_ready), 32'd1);
        check("rst8 valid", 32'(o_valid), 32'd0);
        check("rst8 out", 32'(o_out), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 16-bit suite
        sel = 1'b0;
        run("add16_ovf", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 3'b110, 0);
        run("sub16_zero", 3'b001, 16'h0005, 16'h0005, 16'h0000, 3'b001, 0);
        run("sub16_ovf", 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 3'b010, 0);
        run("and16", 3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000, 0);
        run("not16", 3'b011, 16'h1234, 16'h0000, 16'hFFFF, 3'b100, 0);
        run("or16", 3'b100, 16'h1200, 16'h0034, 16'h1234, 3'b000, 0);
        run("mul16", 3'b111, 16'h0012, 16'h0034, 16'h03A8, 3'b000, 16);
        run("mul16_ffff", 3'b111, 16'hFFFF, 16'hFFFF, 16'h0001, 3'b000, 16);
        run("shl16_15", 3'b110, 16'h0001, 16'h000F, 16'h8000, 3'b100, 0);
        run("shl16_16", 3'b110, 16'h0001, 16'h0010, 16'h0000, 3'b001, 0);

        // Backpressure with ignored in_valid pulses
        issue("xor16_bp", 3'b101, 16'hF0F0, 16'h0FF0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ALUop = 3'b000;
            Ain   = 16'(i + 1);
            Bin   = 16'h0100;
            iv16  = 1'b1;
            @(posedge clk);
            #1;
            iv16 = 1'b0;
            check($sformatf("bp%0d out", i), 32'(o_out), 32'h0000FF00);
            check($sformatf("bp%0d Z", i), 32'(o_z), 32'd4);
            check($sformatf("bp%0d valid", i), 32'(o_valid), 32'd1);
            check($sformatf("bp%0d ready", i), 32'(o_ready), 32'd0);
        end
        consume("xor16_bp");
        check("bp out_kept", 32'(o_out), 32'h0000FF00);

        // 8-bit suite
        sel = 1'b1;
        run("add8_ovf", 3'b000, 16'h007F, 16'h0001, 16'h0080, 3'b110, 0);
        run("sub8_ovf", 3'b001, 16'h0080, 16'h0001, 16'h007F, 3'b010, 0);
        run("mul8", 3'b111, 16'h0012, 16'h0034, 16'h00A8, 3'b100, 8);
        run("mul8_ff", 3'b111, 16'h00FF, 16'h00FF, 16'h0001, 3'b000, 8);
        run("shl8_7", 3'b110, 16'h0001, 16'h0007, 16'h0080, 3'b100, 0);
        run("shl8_8", 3'b110, 16'h0001, 16'h0008, 16'h0000, 3'b001, 0);

        // Reset during the 7th BUSY cycle of a 16-bit multiply
        sel = 1'b0;
        run("mul16_pre", 3'b111, 16'hFFFF, 16'hFFFF, 16'h0001, 3'b000, 16);
        issue("mul16_abort", 3'b111, 16'h0012, 16'h0034);
        repeat (6) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort valid", 32'(o_valid), 32'd0);
        check("abort out", 32'(o_out), 32'd0);
        check("abort Z", 32'(o_z), 32'd0);
        check("abort ready", 32'(o_ready), 32'd1);
        saw_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (o_valid !== 1'b0) saw_valid = 1'b1;
        end
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (o_valid !== 1'b0) saw_valid = 1'b1;
        end
        check("abort no_valid", 32'(saw_valid), 32'd0);
        run("add16_after", 3'b000, 16'h0003, 16'h0004, 16'h0007, 3'b000, 0);
        sel = 1'b1;
        run("add8_after", 3'b000, 16'h0003, 16'h0004, 16'h0007, 3'b000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
